// File: rtl/output_packet_streamer.sv
`default_nettype none
// ============================================================================
// Module   : output_packet_streamer
// Purpose  : Serialises a six-word header, optionally followed by a BRAM sweep
//            (BRAM start..end, addresses 0..count-1), onto a 16-bit AXI-Stream.
//            A 2-entry output FIFO absorbs backpressure. BRAM reads are
//            throttled so that FIFO entries plus in-flight reads never exceed 2.
// Ports    : clk/rst                      - clock, synchronous active-high reset
//            header_word_0..5, send_header, trigger_read, notification_only,
//            rd_bram_start/end, rd_addr_count - packet request
//            bram_rd_en/sel/addr, bram_rd_data - BRAM read port (1-cycle latency)
//            m_axis_tdata/tvalid/tready/tlast  - output stream
//            read_done, busy, drop_err          - status
// Revision : 1.0 - initial release
// ============================================================================
module output_packet_streamer #(
    parameter int DW     = 16,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     header_word_0,
    input  logic [DW-1:0]     header_word_1,
    input  logic [DW-1:0]     header_word_2,
    input  logic [DW-1:0]     header_word_3,
    input  logic [DW-1:0]     header_word_4,
    input  logic [DW-1:0]     header_word_5,
    input  logic              send_header,
    input  logic              trigger_read,
    input  logic              notification_only,
    input  logic [2:0]        rd_bram_start,
    input  logic [2:0]        rd_bram_end,
    input  logic [15:0]       rd_addr_count,
    output logic              bram_rd_en,
    output logic [2:0]        bram_rd_sel,
    output logic [ADDR_W-1:0] bram_rd_addr,
    input  logic [DW-1:0]     bram_rd_data,
    output logic [DW-1:0]     m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              read_done,
    output logic              busy,
    output logic              drop_err
);

    localparam logic [ADDR_W:0]   C_MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   C_CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] C_ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HDR   = 2'd1,
        S_RD    = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [DW-1:0]     hdr_q [0:4];     // header words 1..5
    logic [2:0]        hdr_idx_q;
    logic [2:0]        end_q;
    logic [ADDR_W:0]   count_q;
    logic              is_data_q;       // BRAM sweep follows the header
    logic              done_req_q;      // upstream expects a read_done pulse
    logic [2:0]        sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        last_sel_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic              rdv_q;           // read issued last cycle, data arrives now
    logic              rd_last_q;
    logic              read_done_q;
    logic              drop_err_q;
    logic [DW-1:0]     fifo_data_q [0:1];
    logic              fifo_last_q [0:1];
    logic              wp_q, rp_q;
    logic [1:0]        fifo_cnt_q;

    logic              w_pop, w_push, w_push_hdr, w_hdr_last, w_push_last;
    logic [DW-1:0]     w_hdr_word, w_push_data;
    logic [2:0]        w_occ_next;
    logic              w_rd_window, w_rd_final;
    logic [ADDR_W:0]   w_count_clamped;

    assign m_axis_tvalid = (fifo_cnt_q != 2'd0);
    assign m_axis_tdata  = fifo_data_q[rp_q];
    assign m_axis_tlast  = fifo_last_q[rp_q];
    assign busy          = (state_q != S_IDLE);
    assign read_done     = read_done_q;
    assign drop_err      = drop_err_q;

    assign w_count_clamped = (rd_addr_count > 16'(C_MAX_COUNT)) ? C_MAX_COUNT
                                                                : rd_addr_count[ADDR_W:0];

    always_comb begin
        state_d     = state_q;
        w_pop       = m_axis_tvalid && m_axis_tready;
        w_push_hdr  = 1'b0;
        w_hdr_word  = '0;
        w_hdr_last  = 1'b0;
        // Header word 0 goes straight into the (empty) FIFO on the request
        // edge so it is presented on the very next cycle.
        if (state_q == S_IDLE && send_header) begin
            w_push_hdr = 1'b1;
            w_hdr_word = header_word_0;
        end else if (state_q == S_HDR && (fifo_cnt_q != 2'd2 || w_pop)) begin
            w_push_hdr = 1'b1;
            w_hdr_word = hdr_q[hdr_idx_q];
            w_hdr_last = (hdr_idx_q == 3'd4) && !is_data_q;
        end
        w_push      = w_push_hdr || rdv_q;
        w_push_data = rdv_q ? bram_rd_data : w_hdr_word;
        w_push_last = rdv_q ? rd_last_q : w_hdr_last;
        w_occ_next  = {1'b0, fifo_cnt_q} + {2'b00, w_push} - {2'b00, w_pop};
        // Reads may start in the cycle header word 5 is pushed, so that the
        // first data word lands right behind it with no bubble.
        w_rd_window = (state_q == S_RD) ||
                      (state_q == S_HDR && hdr_idx_q == 3'd4 && w_push_hdr && is_data_q);
        // Issue only if the returning word is guaranteed a FIFO slot next
        // cycle, whatever the consumer does.
        bram_rd_en  = w_rd_window && (w_occ_next < 3'd2);
        w_rd_final  = (sel_q == end_q) && ({1'b0, addr_q} == (count_q - C_CNT_ONE));
        bram_rd_sel  = bram_rd_en ? sel_q  : last_sel_q;
        bram_rd_addr = bram_rd_en ? addr_q : last_addr_q;

        case (state_q)
            S_IDLE:  if (send_header) state_d = S_HDR;
            S_HDR: begin
                if (w_push_hdr && hdr_idx_q == 3'd4) begin
                    if (!is_data_q || (bram_rd_en && w_rd_final)) state_d = S_DRAIN;
                    else                                          state_d = S_RD;
                end
            end
            S_RD:    if (bram_rd_en && w_rd_final) state_d = S_DRAIN;
            S_DRAIN: if (w_pop && m_axis_tlast) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) hdr_q[i] <= '0;
            hdr_idx_q   <= '0;
            end_q       <= '0;
            count_q     <= '0;
            is_data_q   <= 1'b0;
            done_req_q  <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            last_sel_q  <= '0;
            last_addr_q <= '0;
            rdv_q       <= 1'b0;
            rd_last_q   <= 1'b0;
            read_done_q <= 1'b0;
            drop_err_q  <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q[0] <= 1'b0;
            fifo_last_q[1] <= 1'b0;
            wp_q        <= 1'b0;
            rp_q        <= 1'b0;
            fifo_cnt_q  <= '0;
        end else begin
            if (state_q == S_IDLE && send_header) begin
                hdr_q[0]   <= header_word_1;
                hdr_q[1]   <= header_word_2;
                hdr_q[2]   <= header_word_3;
                hdr_q[3]   <= header_word_4;
                hdr_q[4]   <= header_word_5;
                hdr_idx_q  <= '0;
                end_q      <= rd_bram_end;
                count_q    <= w_count_clamped;
                is_data_q  <= trigger_read && !notification_only &&
                              (rd_bram_start <= rd_bram_end) && (rd_addr_count != 16'd0);
                // Degenerate data requests still acknowledge upstream.
                done_req_q <= trigger_read && !notification_only;
                sel_q      <= rd_bram_start;
                addr_q     <= '0;
            end
            if (state_q == S_HDR && w_push_hdr) hdr_idx_q <= hdr_idx_q + 3'd1;

            if (bram_rd_en) begin
                last_sel_q  <= sel_q;
                last_addr_q <= addr_q;
                if ({1'b0, addr_q} == (count_q - C_CNT_ONE)) begin
                    addr_q <= '0;
                    sel_q  <= sel_q + 3'd1;
                end else begin
                    addr_q <= addr_q + C_ADDR_ONE;
                end
            end
            rdv_q     <= bram_rd_en;
            rd_last_q <= bram_rd_en && w_rd_final;

            read_done_q <= (state_q == S_DRAIN) && w_pop && m_axis_tlast && done_req_q;
            if (send_header && state_q != S_IDLE) drop_err_q <= 1'b1;

            if (w_push) begin
                fifo_data_q[wp_q] <= w_push_data;
                fifo_last_q[wp_q] <= w_push_last;
                wp_q              <= ~wp_q;
            end
            if (w_pop) rp_q <= ~rp_q;
            fifo_cnt_q <= w_occ_next[1:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_packet_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_packet_streamer
// Purpose  : Scoreboard bench for output_packet_streamer. Stimulus pushes the
//            expected stream words into a queue; an independent monitor pops
//            and compares on every stream handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_packet_streamer;

    localparam int DW     = 16;
    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     hw0, hw1, hw2, hw3, hw4, hw5;
    logic              send_header, trigger_read, notification_only;
    logic [2:0]        rd_bram_start, rd_bram_end;
    logic [15:0]       rd_addr_count;
    logic              bram_rd_en;
    logic [2:0]        bram_rd_sel;
    logic [ADDR_W-1:0] bram_rd_addr;
    logic [DW-1:0]     bram_rd_data = '0;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic              read_done, busy, drop_err;

    always #5 clk = ~clk;

    output_packet_streamer #(.DW(DW), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .header_word_0(hw0), .header_word_1(hw1), .header_word_2(hw2),
        .header_word_3(hw3), .header_word_4(hw4), .header_word_5(hw5),
        .send_header(send_header), .trigger_read(trigger_read),
        .notification_only(notification_only),
        .rd_bram_start(rd_bram_start), .rd_bram_end(rd_bram_end),
        .rd_addr_count(rd_addr_count),
        .bram_rd_en(bram_rd_en), .bram_rd_sel(bram_rd_sel),
        .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .read_done(read_done), .busy(busy), .drop_err(drop_err)
    );

    // BRAM model: data = {sel, addr}, one cycle after the read strobe.
    always @(posedge clk) begin
        if (bram_rd_en) bram_rd_data <= {4'd0, bram_rd_sel, bram_rd_addr};
    end

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        is_data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   issues, pops, rd_done_cnt, max_out, hs_cnt;
    bit   mon_en = 1'b0;
    bit   rand_mode = 1'b0;
    bit   stalled = 1'b0;
    bit   prev_tlast_hs = 1'b0;
    logic [16:0] held;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    endtask

    // Stream readiness: always ready, or ~30% duty when rand_mode is set.
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) m_axis_tready = ($urandom_range(0, 99) < 30);
            else           m_axis_tready = 1'b1;
        end
    end

    // Monitor / scoreboard checker.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst) begin
            if (bram_rd_en) issues++;
            if (stalled)
                check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, held});
            if (read_done) begin
                rd_done_cnt++;
                check("read_done_timing", prev_tlast_hs, 1);
                check("busy_at_read_done", busy, 0);
            end
            if (m_axis_tvalid && m_axis_tready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    check("extra_word", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("word", {m_axis_tlast, m_axis_tdata}, {e.last, e.data});
                    if (e.is_data) pops++;
                end
            end
            if (issues - pops > max_out) max_out = issues - pops;
            stalled       = m_axis_tvalid && !m_axis_tready;
            held          = {m_axis_tlast, m_axis_tdata};
            prev_tlast_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;
        end else begin
            stalled       = 1'b0;
            prev_tlast_hs = 1'b0;
        end
    end

    task automatic clear_counts();
        issues = 0; pops = 0; rd_done_cnt = 0; max_out = 0; hs_cnt = 0;
    endtask

    task automatic send_pkt(input logic [15:0] h [6], input logic trig, input logic notif,
                            input int st, input int en, input int cnt);
        exp_t e;
        bit   dmode;
        int   eff;
        dmode = trig && !notif && (st <= en) && (cnt != 0);
        eff   = (cnt > 512) ? 512 : cnt;
        for (int i = 0; i < 6; i++) begin
            e.data = h[i]; e.last = (i == 5) && !dmode; e.is_data = 1'b0;
            sb.push_back(e);
        end
        if (dmode) begin
            for (int s = st; s <= en; s++) begin
                for (int a = 0; a < eff; a++) begin
                    e.data    = {4'd0, 3'(s), 9'(a)};
                    e.last    = (s == en) && (a == eff - 1);
                    e.is_data = 1'b1;
                    sb.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
        hw0 = h[0]; hw1 = h[1]; hw2 = h[2]; hw3 = h[3]; hw4 = h[4]; hw5 = h[5];
        trigger_read = trig; notification_only = notif;
        rd_bram_start = 3'(st); rd_bram_end = 3'(en); rd_addr_count = 16'(cnt);
        send_header = 1'b1;
        @(posedge clk);
        #1;
        send_header = 1'b0;
        check("start_busy",   busy, 1);
        check("start_tvalid", m_axis_tvalid, 1);
        check("start_tdata",  m_axis_tdata, h[0]);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int cyc = 0;
        while ((sb.size() != 0 || busy) && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({nm, "_complete"}, (cyc < budget), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string nm);
        check({nm, "_tvalid"}, m_axis_tvalid, 0);
        check({nm, "_tlast"},  m_axis_tlast, 0);
        check({nm, "_tdata"},  m_axis_tdata, 0);
        check({nm, "_rd_en"},  bram_rd_en, 0);
        check({nm, "_rd_sel"}, bram_rd_sel, 0);
        check({nm, "_rd_addr"}, bram_rd_addr, 0);
        check({nm, "_read_done"}, read_done, 0);
        check({nm, "_busy"},   busy, 0);
        check({nm, "_drop_err"}, drop_err, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] h [6];
        rst = 1'b1; send_header = 1'b0; trigger_read = 1'b0; notification_only = 1'b0;
        hw0 = '0; hw1 = '0; hw2 = '0; hw3 = '0; hw4 = '0; hw5 = '0;
        rd_bram_start = '0; rd_bram_end = '0; rd_addr_count = '0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // Header-only notification.
        h = '{16'hC0DE, 16'h0001, 16'h0003, 16'h0000, 16'h0000, 16'h0000};
        clear_counts();
        send_pkt(h, 1'b0, 1'b1, 0, 0, 0);
        wait_done("hdr_only", 50);
        check("hdr_only_reads", issues, 0);
        check("hdr_only_read_done", rd_done_cnt, 0);

        // Full sweep: 8 BRAMs x 512 words.
        h = '{16'hDA7A, 16'h0002, 16'h0000, 16'h0007, 16'h0200, 16'h1000};
        clear_counts();
        send_pkt(h, 1'b1, 1'b0, 0, 7, 512);
        wait_done("full", 5000);
        check("full_reads", issues, 4096);
        check("full_words", hs_cnt, 4102);
        check("full_read_done", rd_done_cnt, 1);

        // Backpressure with random ready.
        h = '{16'hBAC0, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};
        clear_counts();
        rand_mode = 1'b1;
        send_pkt(h, 1'b1, 1'b0, 2, 2, 8);
        wait_done("bp", 1000);
        rand_mode = 1'b0;
        check("bp_reads", issues, 8);
        check("bp_read_done", rd_done_cnt, 1);
        check("bp_max_outstanding_le2", (max_out <= 2), 1);

        // Degenerate data requests: count 0, then start > end.
        h = '{16'hDE60, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
        clear_counts();
        send_pkt(h, 1'b1, 1'b0, 0, 3, 0);
        wait_done("degen_cnt0", 50);
        check("degen_cnt0_reads", issues, 0);
        check("degen_cnt0_read_done", rd_done_cnt, 1);
        clear_counts();
        send_pkt(h, 1'b1, 1'b0, 5, 3, 4);
        wait_done("degen_order", 50);
        check("degen_order_reads", issues, 0);
        check("degen_order_read_done", rd_done_cnt, 1);

        // Overlapping request mid-packet is dropped.
        h = '{16'h0AE1, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
        clear_counts();
        send_pkt(h, 1'b1, 1'b0, 1, 1, 4);
        @(posedge clk);
        #1;
        hw0 = 16'hFFFF; trigger_read = 1'b0; notification_only = 1'b1;
        send_header = 1'b1;
        @(posedge clk);
        #1;
        send_header = 1'b0;
        check("overlap_drop_err", drop_err, 1);
        wait_done("overlap", 100);
        check("overlap_drop_err_sticky", drop_err, 1);
        check("overlap_reads", issues, 4);
        check("overlap_read_done", rd_done_cnt, 1);

        // Reset during a data phase, then a clean header-only packet.
        h = '{16'h5E55, 16'h0001, 16'h0000, 16'h0000, 16'h0200, 16'h0000};
        clear_counts();
        send_pkt(h, 1'b1, 1'b0, 0, 0, 512);
        repeat (20) @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check_idle_zero("midreset");
        rst = 1'b0;
        clear_counts();
        mon_en = 1'b1;
        h = '{16'hBEEF, 16'h0009, 16'h0008, 16'h0007, 16'h0006, 16'h0005};
        send_pkt(h, 1'b0, 1'b1, 0, 0, 0);
        wait_done("post_reset", 50);
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_words", hs_cnt, 6);
        check("post_reset_reads", issues, 0);
        check("post_reset_read_done", rd_done_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/output_packet_streamer.md
# output_packet_streamer

Serialises result packets onto the 16-bit stream toward the PS, directly downstream of the output manager. On a `send_header` strobe it latches six header words and emits them, then optionally sweeps BRAMs `rd_bram_start..rd_bram_end` over addresses `0..rd_addr_count-1` and streams the read data. It asserts `tlast` on the final word and returns `read_done` for data packets. Backpressure is absorbed by a 2-entry output FIFO with read-issue throttling.

## Interface
- `DW`, 16, stream/BRAM data width
- `ADDR_W`, 9, BRAM address width (512 words per BRAM)
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `header_word_0`..`header_word_5`  in  16 each  header words, valid in the `send_header` cycle
- `send_header`  in  1  one-cycle start strobe
- `trigger_read`  in  1  packet carries BRAM data (sampled with `send_header`)
- `notification_only`  in  1  header-only packet; overrides `trigger_read`
- `rd_bram_start`, `rd_bram_end`  in  3 each  first and last BRAM index (inclusive)
- `rd_addr_count`  in  16  words per BRAM
- `bram_rd_en`  out  1  read strobe
- `bram_rd_sel`  out  3  BRAM index of the read
- `bram_rd_addr`  out  ADDR_W  read address
- `bram_rd_data`  in  DW  muxed read data, valid exactly 1 cycle after `bram_rd_en`
- `m_axis_tdata`  out  16  stream data
- `m_axis_tvalid`  out  1  stream valid
- `m_axis_tready`  in  1  stream ready
- `m_axis_tlast`  out  1  final word of packet
- `read_done`  out  1  one-cycle pulse: data packet fully transferred
- `busy`  out  1  packet in progress
- `drop_err`  out  1  sticky: `send_header` arrived while busy

## Operation
- Reset value of every output is 0. Reset also flushes the FIFO, discards any in-flight read, and sends the FSM to IDLE. Reset mid-packet abandons the packet with no `tlast` and no `read_done`.
- IDLE: on `send_header`, the block latches the headers, `start`, `end`, count and mode, then goes to HDR.
  - Mode DATA requires `trigger_read` = 1, `notification_only` = 0, `start` ≤ `end` and count ≠ 0. Every other combination is mode HDR_ONLY.
  - Count is clamped to 2^ADDR_W.
- HDR: the six header words are written into the FIFO in order, one per cycle when the FIFO has space.
  - In HDR_ONLY, word 5 carries `tlast` and the FSM goes to DRAIN.
  - In DATA, the FSM goes to RD after word 5.
- RD: reads issue in order BRAM `start` addr 0..count-1, then `start`+1, …, through `end`.
  - A read issues only when FIFO occupancy + in-flight < 2.
  - Each read's data enters the FIFO the next cycle.
  - The last data word carries `tlast`. After the last issue, the FSM goes to DRAIN.
  - Total data words = (`end`−`start`+1)×count, at most 4096.
- DRAIN: the FSM waits until the FIFO is empty and the last word has handshaken.
  - For a DATA packet, it pulses `read_done` and goes to IDLE.
  - For HDR_ONLY, it goes to IDLE with no `read_done`.
  - A DATA request with count 0 or `start` > `end` falls back to HDR_ONLY but still pulses `read_done`, so the upstream manager cannot hang.
- `send_header` outside IDLE is ignored and sets `drop_err`, which clears only on `rst`.
- The stream follows AXI-Stream rules:
  - `tdata`/`tlast` hold stable while `tvalid` && !`tready`.
  - `tvalid` never drops without a handshake.
  - A handshake is `tvalid` && `tready`.
- The FIFO accepts a push and a pop in the same cycle. The throttle guarantees it never overflows.

## Timing
- `send_header` sampled at edge T: `busy` = 1 and `m_axis_tvalid` = 1 with `header_word_0` from T+1.
- Under constant `tready` = 1, one word per cycle, with no bubble between header word 5 and the first data word.
- First `bram_rd_en` no later than the cycle header word 4 handshakes.
- `read_done` asserts the cycle after the final `tlast` handshake. `busy` falls in that same cycle.
- A new `send_header` is accepted in the `read_done` cycle or later.
- `bram_rd_sel`/`bram_rd_addr` are valid only while `bram_rd_en` = 1 and hold their last value otherwise.

## Test plan
- HDR_ONLY: `send_header`, `notification_only` = 1, headers C0DE, 0001, 0003, 0, 0, 0, `tready` = 1 → 6 words in order, `tlast` on 6th, no `bram_rd_en`, no `read_done`.
- DATA full: headers DA7A, 0002, …, 4096; `start` = 0, `end` = 7, count = 512; BRAM model returns {sel, addr}; `tready` = 1 → 4102 words, data sequential over sel 0..7 × addr 0..511, `tlast` only on word 4102, `read_done` one cycle later.
- Backpressure: `start` = `end` = 2, count = 8, random `tready` at 30% duty → all 8 words in order, no loss or duplication, `tdata` stable while stalled, at most 2 reads outstanding.
- Degenerate: `trigger_read` = 1, count = 0 (and separately `start` = 5, `end` = 3) → 6 header words with `tlast` on word 6, `read_done` pulse, no reads.
- Overlap: `send_header` again mid-packet → ignored, `drop_err` = 1 and stays set, first packet intact.
- Reset: `rst` asserted during the data phase of a 512-word read, then a new HDR_ONLY packet → all outputs 0 the cycle after reset, new packet emits exactly 6 words with no stale data.
